// File: rtl/aes_state_mover_if.sv
// Handshake and register-file bus of the AES state mover.
// The slave modport is the mover; the master modport is the command source and register file.
interface aes_state_mover_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [3:0]   cmd_base;
  logic [127:0] cmd_data;
  logic [3:0]   rf_fila1;
  logic [1:0]   rf_columna;
  logic [31:0]  rf_data_in;
  logic         rf_wr_en;
  logic         rf_col_write;
  logic         rf_col_read;
  logic [31:0]  rf_data_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         done;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_base, cmd_data, rf_data_out, rsp_ready,
    output cmd_ready, rf_fila1, rf_columna, rf_data_in, rf_wr_en, rf_col_write,
           rf_col_read, rsp_valid, rsp_data, done
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_base, cmd_data, rf_data_out, rsp_ready,
    input  cmd_ready, rf_fila1, rf_columna, rf_data_in, rf_wr_en, rf_col_write,
           rf_col_read, rsp_valid, rsp_data, done
  );
endinterface

// File: rtl/aes_state_mover.sv
// Moves a 128-bit AES state between a command port and a column-addressed register file.
// state | meaning
// IDLE  | ready for a command
// WRITE | load: one column per cycle into the register file, col 0..3
// READ  | store: one column per cycle out of the register file, col 0..3
// RESP  | store result held until the consumer accepts it
module aes_state_mover (
  input logic               clk,
  input logic               rst_n,
  aes_state_mover_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   col;
  logic [3:0]   base;
  logic [127:0] data_q;
  logic [127:0] rsp_q;
  logic [6:0]   col_msb;

  // Column c occupies bits [127-32c -: 32]; 127-32c is {~c, 5'h1f}.
  assign col_msb = {~col, 5'h1f};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      col    <= 2'd0;
      base   <= 4'd0;
      data_q <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            base   <= bus.cmd_base;
            data_q <= bus.cmd_data;
            col    <= 2'd0;
            state  <= bus.cmd_dir ? READ : WRITE;
          end
        end
        WRITE: begin
          col <= col + 2'd1;
          if (col == 2'd3) state <= IDLE;
        end
        READ: begin
          rsp_q[col_msb -: 32] <= bus.rf_data_out;
          col <= col + 2'd1;
          if (col == 2'd3) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state == IDLE);
  assign bus.rf_fila1     = base;
  assign bus.rf_wr_en     = (state == WRITE);
  assign bus.rf_col_write = (state == WRITE);
  assign bus.rf_col_read  = (state == READ);
  assign bus.rf_columna   = (state == WRITE || state == READ) ? col : 2'd0;
  assign bus.rf_data_in   = (state == WRITE) ? data_q[col_msb -: 32] : 32'd0;
  assign bus.done         = (state == WRITE) && (col == 2'd3);
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_data     = rsp_q;

endmodule

// File: tb/tb_aes_state_mover.sv
// Directed bench for aes_state_mover: table of load/store commands against a
// row/byte register-file model, plus hand sequences for stall, busy and reset cases.
module tb_aes_state_mover;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_state_mover_if bus ();

  aes_state_mover dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: row r holds one byte per column, column 0 in the top byte.
  logic [31:0] rows [16] = '{default: 32'd0};
  logic [31:0] rd;

  always @(posedge clk) begin
    if (bus.rf_wr_en && bus.rf_col_write) begin
      for (int i = 0; i < 4; i++)
        rows[(int'(bus.rf_fila1) + i) % 16][31 - 8*int'(bus.rf_columna) -: 8] <= bus.rf_data_in[31 - 8*i -: 8];
    end
  end

  always_comb begin
    rd = 32'd0;
    for (int i = 0; i < 4; i++)
      rd[31 - 8*i -: 8] = rows[(int'(bus.rf_fila1) + i) % 16][31 - 8*int'(bus.rf_columna) -: 8];
  end
  assign bus.rf_data_out = rd;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  typedef struct {
    logic         dir;
    logic [3:0]   base;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, " ready before command"}, bus.cmd_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("v%0d", n);
    @(negedge clk);
    wait_ready(tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = v.dir;
    bus.cmd_base  = v.base;
    bus.cmd_data  = v.data;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = ~v.base;
    bus.cmd_data  = ~v.data;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s c%0d wr_en", tag, k), bus.rf_wr_en, !v.dir);
      chk($sformatf("%s c%0d col_write", tag, k), bus.rf_col_write, !v.dir);
      chk($sformatf("%s c%0d col_read", tag, k), bus.rf_col_read, v.dir);
      chk($sformatf("%s c%0d columna", tag, k), bus.rf_columna, k);
      chk($sformatf("%s c%0d fila1", tag, k), bus.rf_fila1, v.base);
      chk($sformatf("%s c%0d done", tag, k), bus.done, (!v.dir && k == 3));
      if (!v.dir)
        chk($sformatf("%s c%0d data_in", tag, k), bus.rf_data_in, v.exp[127 - 32*k -: 32]);
      @(negedge clk);
    end
    if (!v.dir) begin
      exp_done++;
      chk({tag, " ready at T+5"}, bus.cmd_ready, 1);
      chk({tag, " wr_en idle"}, bus.rf_wr_en, 0);
      chk({tag, " columna idle"}, bus.rf_columna, 0);
      chk({tag, " data_in idle"}, bus.rf_data_in, 0);
      chk({tag, " fila1 held"}, bus.rf_fila1, v.base);
    end else begin
      chk({tag, " rsp_valid at T+5"}, bus.rsp_valid, 1);
      chk({tag, " rsp_data"}, bus.rsp_data, v.exp);
      chk({tag, " busy in resp"}, bus.cmd_ready, 0);
      @(negedge clk);
      chk({tag, " ready after rsp"}, bus.cmd_ready, 1);
      chk({tag, " rsp_valid cleared"}, bus.rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 4'd4,  128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    vecs[1] = '{1'b1, 4'd4,  128'h0,                                     128'h00112233_44556677_8899AABB_CCDDEEFF};
    vecs[2] = '{1'b0, 4'd14, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
    vecs[3] = '{1'b1, 4'd14, 128'h0,                                     128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
    vecs[4] = '{1'b1, 4'd5,  128'h0,                                     128'h11223300_55667700_99AABB00_DDEEFF00};
    vecs[5] = '{1'b1, 4'd15, 128'h0,                                     128'hADBEEF00_23456700_ABCDEF00_FEF00D00};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_base  = 4'd0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset wr_en", bus.rf_wr_en, 0);
    chk("reset col_read", bus.rf_col_read, 0);
    chk("reset fila1", bus.rf_fila1, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
    chk("reset done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", bus.cmd_ready, 1);

    for (int n = 0; n < 6; n++) begin
      run_vec(vecs[n], n);
      if (n == 0) begin
        chk("row4", rows[4], 32'h004488CC);
        chk("row5", rows[5], 32'h115599DD);
        chk("row6", rows[6], 32'h2266AAEE);
        chk("row7", rows[7], 32'h3377BBFF);
      end
      if (n == 2) begin
        chk("row14", rows[14], 32'hDE0189CA);
        chk("row15", rows[15], 32'hAD23ABFE);
        chk("row0",  rows[0],  32'hBE45CDF0);
        chk("row1",  rows[1],  32'hEF670D0D ^ 32'h0000E200);
        chk("row2 untouched", rows[2], 32'h0);
      end
    end

    // Store with the consumer stalled for six cycles.
    bus.rsp_ready = 1'b0;
    wait_ready("stall");
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_base  = 4'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall %0d rsp_valid", i), bus.rsp_valid, 1);
      chk($sformatf("stall %0d rsp_data", i), bus.rsp_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk($sformatf("stall %0d busy", i), bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall ready after rsp", bus.cmd_ready, 1);
    chk("stall rsp_valid cleared", bus.rsp_valid, 0);

    // Command held valid with changing fields during a load.
    wait_ready("busy");
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_base  = 4'd9;
    bus.cmd_data  = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.cmd_base = 4'd2;
      bus.cmd_data = {4{$urandom()}};
      if (k == 3) bus.cmd_valid = 1'b0;
      chk($sformatf("busy c%0d fila1", k), bus.rf_fila1, 9);
      chk($sformatf("busy c%0d columna", k), bus.rf_columna, k);
      @(negedge clk);
    end
    exp_done++;
    chk("busy ready", bus.cmd_ready, 1);
    chk("busy no rewrite", bus.rf_wr_en, 0);
    chk("row9",  rows[9],  32'h0105090D);
    chk("row10", rows[10], 32'h02060A0E);
    chk("row11", rows[11], 32'h03070B0F);
    chk("row12", rows[12], 32'h04080C10);

    // Reset during the second write cycle.
    wait_ready("rstw");
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_base  = 4'd3;
    bus.cmd_data  = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rstw first write", bus.rf_wr_en, 1);
    @(negedge clk);
    chk("rstw second write", bus.rf_columna, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw wr_en", bus.rf_wr_en, 0);
    chk("rstw col_write", bus.rf_col_write, 0);
    chk("rstw col_read", bus.rf_col_read, 0);
    chk("rstw done", bus.done, 0);
    chk("rstw fila1", bus.rf_fila1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstw no access", bus.rf_wr_en, 0);
    end
    chk("rstw ready", bus.cmd_ready, 1);

    // Reset while a result is pending.
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_base  = 4'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstr rsp_valid before", bus.rsp_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstr rsp_valid", bus.rsp_valid, 0);
    chk("rstr rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstr ready", bus.cmd_ready, 1);

    chk("done pulse count", done_cnt, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
